speaker_serializer: RTL and testbench
=====================================

// Module: speaker_serializer
// PURPOSE
//   Audio back-end stage. Takes 16-bit left/right PCM samples from the note/tone
//   generator and drives an I2S DAC (Pmod I2S class): MCLK, LRCK, SCK and SDIN.
//   Derives all audio clocks from one free-running counter on the system clock.
//   Requests a new stereo sample once per frame and shifts it out MSB-first.
// PARAMETERS
//   MCLK_DIV_LOG2  2   MCLK = clk / 2^MCLK_DIV_LOG2 (default 25 MHz at 100 MHz)
//   LRCK_DIV_LOG2  9   frame length in clk cycles = 2^LRCK_DIV_LOG2 (512)
//   SAMPLE_W       16  bits per channel. Fixed: 2*SAMPLE_W SCK periods per frame.
//   SCK_DIV_LOG2 is derived: LRCK_DIV_LOG2-5. Elaboration fails if it is <1.
// PORTS
//   clk         in   1         system clock. All logic is posedge.
//   rst_n       in   1         asynchronous, active-low reset
//   mute        in   1         1: the samples latched this frame are forced to 0
//   sample_l    in   SAMPLE_W  left sample, signed two's complement
//   sample_r    in   SAMPLE_W  right sample, signed two's complement
//   sample_req  out  1         one-cycle pulse; inputs are latched in this cycle
//   audio_mclk  out  1         DAC master clock
//   audio_lrck  out  1         word select: 0 = left half, 1 = right half
//   audio_sck   out  1         serial bit clock
//   audio_sdin  out  1         serial data. Changes on SCK falling edge.
// BEHAVIOUR
//   - cnt[LRCK_DIV_LOG2-1:0] increments every clk and wraps at 2^LRCK_DIV_LOG2.
//   - audio_mclk = cnt[MCLK_DIV_LOG2-1], audio_sck = cnt[SCK_DIV_LOG2-1],
//     audio_lrck = cnt[LRCK_DIV_LOG2-1]. All are direct counter bits, glitch-free.
//   - fall_tick: cnt[SCK_DIV_LOG2-1:0] is all-ones (SCK falls on the next edge).
//   - half_tick: cnt[LRCK_DIV_LOG2-2:0] is all-ones.
//   - frame_tick: cnt is all-ones. frame_tick implies half_tick and fall_tick.
//   - frame_tick actions:
//     - sample_req is 1 for exactly this cycle.
//     - sample_l is loaded straight into the shift reg sh.
//     - sample_r is captured into hold_r.
//     - If mute is 1, both loaded values are 0.
//   - half_tick && !frame_tick: sh <= hold_r.
//   - On every fall_tick, audio_sdin <= sh[SAMPLE_W-1].
//   - When fall_tick is set and no load happens, sh <= sh << 1.
//   - This gives the I2S one-bit delay:
//     - slot 0 of each half carries the LSB of the previous channel;
//     - the MSB appears in slot 1.
//   - Reset (asynchronous, takes effect mid-frame too):
//     - cnt, sh, hold_r, sample_req and audio_sdin all go to 0;
//     - all clock outputs are therefore 0.
//     - After release the first sample_req occurs at clk cycle 2^LRCK_DIV_LOG2-1.
//     - The first frame after reset transmits zeros.
//   - Input changes between frame_ticks have no effect. No backpressure.
//   - sample_req period: exactly 2^LRCK_DIV_LOG2 cycles.
//   - mute is sampled only at frame_tick. It never truncates a frame in flight.
// STRUCTURE
//   - Package audio_pkg holds:
//     - SAMPLE_W and the default divider exponents;
//     - a typedef for a signed SAMPLE_W sample.
//   - One sub-module, audio_clk_gen:
//     - counter, clock outputs, fall_tick/half_tick/frame_tick.
//   - The top level holds sh, hold_r, mute handling and audio_sdin.
// TESTING
//   1 Reset: hold rst_n=0 for 10 clk. All outputs are 0.
//     After release, sample_req first rises at cycle 511, then every 512 cycles.
//   2 Clock ratios at defaults:
//     - MCLK period 4 clk; SCK period 16 clk;
//     - LRCK period 512 clk at 50% duty;
//     - 32 SCK falling edges per LRCK period.
//   3 Data: sample_l=16'hA5F0, sample_r=16'h0F0F. Sample SDIN on SCK rising edges.
//     - Left slots 1..15 read A5F0 bits 15..1.
//     - Right slot 0 reads bit0 of A5F0 (0). Right slots 1..15 read 0F0F bits 15..1.
//   4 Mute: set mute=1 with sample_l=16'hFFFF for one frame.
//     - That frame's SDIN is all zeros.
//     - Clear mute: the next frame carries FFFF.
//   5 Input stability: change sample_l mid-frame (cnt=100).
//     - The transmitted word equals the value present at the prior frame_tick.
//   6 Reset mid-frame: assert rst_n=0 at cnt=300.
//     - Outputs are 0 immediately, without waiting for a clock edge.
//     - Test 1 timing holds after release.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio back-end.
// The sample width is fixed; the divider exponents are only defaults.
package audio_pkg;

    localparam int SAMPLE_W          = 16;
    localparam int MCLK_DIV_LOG2_DEF = 2;
    localparam int LRCK_DIV_LOG2_DEF = 9;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/audio_clk_gen.sv
// Free-running frame counter. Every audio clock is a direct counter bit, so none can glitch.
// The ticks mark the last clk cycle before an SCK fall, a half-frame boundary and a frame boundary.
module audio_clk_gen #(
    parameter int MCLK_DIV_LOG2 = audio_pkg::MCLK_DIV_LOG2_DEF,
    parameter int LRCK_DIV_LOG2 = audio_pkg::LRCK_DIV_LOG2_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic audio_mclk,
    output logic audio_sck,
    output logic audio_lrck,
    output logic fall_tick,
    output logic half_tick,
    output logic frame_tick
);

    // 32 SCK periods per frame (2 x 16 bits), so SCK runs 5 octaves above LRCK.
    localparam int SCK_DIV_LOG2 = LRCK_DIV_LOG2 - 5;
    localparam int CNT_W        = LRCK_DIV_LOG2;

    if (SCK_DIV_LOG2 < 1) begin : g_bad_lrck_div
        $error("audio_clk_gen: LRCK_DIV_LOG2 must be at least 6");
    end
    if (MCLK_DIV_LOG2 < 1 || MCLK_DIV_LOG2 > LRCK_DIV_LOG2) begin : g_bad_mclk_div
        $error("audio_clk_gen: MCLK_DIV_LOG2 out of range");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign audio_mclk = cnt_q[MCLK_DIV_LOG2-1];
    assign audio_sck  = cnt_q[SCK_DIV_LOG2-1];
    assign audio_lrck = cnt_q[CNT_W-1];

    assign fall_tick  = &cnt_q[SCK_DIV_LOG2-1:0];
    assign half_tick  = &cnt_q[CNT_W-2:0];
    assign frame_tick = &cnt_q;

endmodule

// File: rtl/speaker_serializer.sv
// I2S serializer: latches a stereo sample once per frame and shifts it out MSB-first.
// SDIN lags the word-select edge by one SCK slot, as I2S expects.
module speaker_serializer
    import audio_pkg::*;
#(
    parameter int MCLK_DIV_LOG2 = MCLK_DIV_LOG2_DEF,
    parameter int LRCK_DIV_LOG2 = LRCK_DIV_LOG2_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    mute,
    input  sample_t sample_l,
    input  sample_t sample_r,
    output logic    sample_req,
    output logic    audio_mclk,
    output logic    audio_lrck,
    output logic    audio_sck,
    output logic    audio_sdin
);

    logic fall_tick;
    logic half_tick;
    logic frame_tick;

    audio_clk_gen #(
        .MCLK_DIV_LOG2 (MCLK_DIV_LOG2),
        .LRCK_DIV_LOG2 (LRCK_DIV_LOG2)
    ) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .audio_mclk (audio_mclk),
        .audio_sck  (audio_sck),
        .audio_lrck (audio_lrck),
        .fall_tick  (fall_tick),
        .half_tick  (half_tick),
        .frame_tick (frame_tick)
    );

    logic [SAMPLE_W-1:0] sh_q;
    logic [SAMPLE_W-1:0] sh_d;
    logic [SAMPLE_W-1:0] hold_r_q;
    logic [SAMPLE_W-1:0] hold_r_d;
    logic                sdin_q;
    logic                sdin_d;

    // The sample fed out of sh is captured on the same edge that reloads it, giving the one-slot delay.
    always_comb begin
        sh_d     = sh_q;
        hold_r_d = hold_r_q;
        sdin_d   = sdin_q;
        if (fall_tick) begin
            sdin_d = sh_q[SAMPLE_W-1];
        end
        if (frame_tick) begin
            sh_d     = mute ? '0 : sample_l;
            hold_r_d = mute ? '0 : sample_r;
        end else if (half_tick) begin
            sh_d = hold_r_q;
        end else if (fall_tick) begin
            sh_d = {sh_q[SAMPLE_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= '0;
            hold_r_q <= '0;
            sdin_q   <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            hold_r_q <= hold_r_d;
            sdin_q   <= sdin_d;
        end
    end

    assign sample_req = frame_tick;
    assign audio_sdin = sdin_q;

endmodule

// File: tb/tb_speaker_serializer.sv
// Directed bench for speaker_serializer at default dividers (512-cycle frame, 16-cycle SCK).
// Each captured frame is packed slot0..slot31 MSB-first: {prev_right[0], left, right[15:1]}.
module tb_speaker_serializer;

    logic        clk;
    logic        rst_n;
    logic        mute;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_req;
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;

    int n_cmp;
    int n_err;
    int pos;

    logic [31:0] cap;
    int          first_req;
    int          n_req;
    int          n_mclk_rise;
    int          n_sck_rise;
    int          n_sck_fall;
    int          n_lrck_high;
    int          n_lrck_rise;

    speaker_serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mute       (mute),
        .sample_l   (sample_l),
        .sample_r   (sample_r),
        .sample_req (sample_req),
        .audio_mclk (audio_mclk),
        .audio_lrck (audio_lrck),
        .audio_sck  (audio_sck),
        .audio_sdin (audio_sdin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pos = (pos + 1) % 512;
    endtask

    task automatic goto_pos(input int target);
        for (int i = 0; i < 512 && pos != target; i++) step();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"},  {31'd0, sample_req}, 32'd0);
        check({tag, "_mclk"}, {31'd0, audio_mclk}, 32'd0);
        check({tag, "_sck"},  {31'd0, audio_sck},  32'd0);
        check({tag, "_lrck"}, {31'd0, audio_lrck}, 32'd0);
        check({tag, "_sdin"}, {31'd0, audio_sdin}, 32'd0);
    endtask

    // Runs one full frame starting at pos 0, sampling SDIN at SCK rising edges (pos%16 == 8).
    task automatic capture_frame(input int chg_pos, input logic [15:0] chg_val);
        logic p_mclk, p_sck, p_lrck;
        cap = '0;
        first_req = -1;
        n_req = 0;
        n_mclk_rise = 0;
        n_sck_rise = 0;
        n_sck_fall = 0;
        n_lrck_high = 0;
        n_lrck_rise = 0;
        p_mclk = audio_mclk;
        p_sck  = audio_sck;
        p_lrck = audio_lrck;
        for (int i = 0; i < 512; i++) begin
            if (i > 0) begin
                if (!p_mclk && audio_mclk) n_mclk_rise++;
                if (!p_sck && audio_sck)   n_sck_rise++;
                if (p_sck && !audio_sck)   n_sck_fall++;
                if (!p_lrck && audio_lrck) n_lrck_rise++;
            end
            p_mclk = audio_mclk;
            p_sck  = audio_sck;
            p_lrck = audio_lrck;
            if (audio_lrck) n_lrck_high++;
            if (sample_req) begin
                n_req++;
                if (first_req < 0) first_req = pos;
            end
            if (pos % 16 == 8) cap[31 - pos / 16] = audio_sdin;
            if (pos == chg_pos) sample_l = chg_val;
            step();
        end
        if (!p_mclk && audio_mclk) n_mclk_rise++;
        if (!p_sck && audio_sck)   n_sck_rise++;
        if (p_sck && !audio_sck)   n_sck_fall++;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        pos      = 0;
        rst_n    = 1'b0;
        mute     = 1'b0;
        sample_l = 16'h0000;
        sample_r = 16'h0000;

        // Reset held for 10 clocks
        repeat (10) step();
        check_outputs_zero("rst");
        rst_n = 1'b1;
        pos   = 0;

        // Frame 0: transmits zeros; loads A5F0/0F0F at its end
        sample_l = 16'hA5F0;
        sample_r = 16'h0F0F;
        capture_frame(-1, 16'h0);
        check("f0_data",      cap, 32'h0000_0000);
        check("f0_first_req", first_req, 32'd511);
        check("f0_n_req",     n_req, 32'd1);

        // Frame 1: A5F0 / 0F0F, plus clock ratio checks
        mute     = 1'b1;
        sample_l = 16'hFFFF;
        sample_r = 16'hFFFF;
        capture_frame(-1, 16'h0);
        check("f1_data",       cap, {1'b0, 16'hA5F0, 15'h0787});
        check("f1_left_s1_15", {17'd0, cap[30:16]}, 32'h0000_52F8);
        check("f1_right_s0",   {31'd0, cap[15]}, 32'd0);
        check("f1_right_s1_15",{17'd0, cap[14:0]}, 32'h0000_0787);
        check("f1_req_pos",    first_req, 32'd511);
        check("f1_n_req",      n_req, 32'd1);
        check("mclk_rises",    n_mclk_rise, 32'd128);
        check("sck_rises",     n_sck_rise, 32'd32);
        check("sck_falls",     n_sck_fall, 32'd32);
        check("lrck_high",     n_lrck_high, 32'd256);
        check("lrck_rises",    n_lrck_rise, 32'd1);

        // Frame 2: muted; slot 0 still carries 0F0F bit0 from the previous frame
        mute     = 1'b0;
        sample_l = 16'hFFFF;
        sample_r = 16'h1234;
        capture_frame(-1, 16'h0);
        check("f2_mute_slot0", {31'd0, cap[31]}, 32'd1);
        check("f2_mute_rest",  {1'b0, cap[30:0]}, 32'd0);

        // Frame 3: FFFF / 1234 after mute cleared
        sample_l = 16'h3C3C;
        sample_r = 16'hC3C3;
        capture_frame(-1, 16'h0);
        check("f3_data", cap, {1'b0, 16'hFFFF, 15'h091A});

        // Frame 4: sample_l changed mid-frame at cnt=100 must not disturb 3C3C
        capture_frame(100, 16'h1111);
        check("f4_data", cap, {1'b0, 16'h3C3C, 15'h61E1});

        // Frame 5 carries the late 1111; reset lands mid-frame at cnt=300
        goto_pos(300);
        check("pre_rst_lrck", {31'd0, audio_lrck}, 32'd1);
        check("pre_rst_sck",  {31'd0, audio_sck},  32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        repeat (10) step();
        check_outputs_zero("rst2");
        rst_n = 1'b1;
        pos   = 0;
        capture_frame(-1, 16'h0);
        check("r2_data",      cap, 32'h0000_0000);
        check("r2_first_req", first_req, 32'd511);
        check("r2_n_req",     n_req, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
